// File: rtl/aq_spsram_fifo_ctrl.sv
// 64x88 single-port SRAM FIFO controller with a 2-entry output buffer.
// Optional AQ_SPSRAM_FIFO_BYPASS_EN: empty-queue pushes skip the SRAM.
module aq_spsram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 88
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  flush,
   input  logic                  push_vld,
   output logic                  push_rdy,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_vld,
   input  logic                  pop_rdy,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [6:0]            fifo_cnt,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(1 << ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         sram_cnt;
   logic                  rd_inflight;
   logic [1:0]            ob_cnt;
   logic                  last_grant;
   logic [DATA_WIDTH-1:0] ob0;
   logic [DATA_WIDTH-1:0] ob1;

   logic                  full;
   logic                  rd_elig;
   logic                  wr_req;
   logic                  grant_rd;
   logic                  push_fire;
   logic                  pop_fire;
   logic                  byp;
   logic                  do_wr;
   logic                  do_rd;
   logic                  fill;
   logic [DATA_WIDTH-1:0] fill_data;

   assign full    = (sram_cnt == FULL_CNT);
   assign rd_elig = (sram_cnt != '0) &&
                    (({1'b0, ob_cnt} + {2'b00, rd_inflight}) < 3'd2);
   assign wr_req  = push_vld && !full;

   // Contested cycles go to whichever side did not win the last contest.
   assign grant_rd = rd_elig && (!wr_req || !last_grant);

   assign push_rdy  = !full && !grant_rd && !flush;
   assign push_fire = push_vld && push_rdy;
   assign pop_vld   = (ob_cnt != 2'd0);
   assign pop_fire  = pop_vld && pop_rdy;
   assign pop_data  = ob0;

`ifdef AQ_SPSRAM_FIFO_BYPASS_EN
   assign byp = push_fire && (sram_cnt == '0) && !rd_inflight &&
                (ob_cnt != 2'd2);
`else
   assign byp = 1'b0;
`endif

   assign do_wr = push_fire && !byp;
   assign do_rd = grant_rd;

   assign fill      = rd_inflight || byp;
   assign fill_data = rd_inflight ? sram_q : push_data;

   assign sram_cen  = !(do_wr || do_rd);
   assign sram_gwen = do_wr;
   assign sram_wen  = {DATA_WIDTH{do_wr}};
   assign sram_d    = push_data;
   assign sram_a    = do_wr ? wr_ptr : (do_rd ? rd_ptr : '0);

   assign fifo_cnt = 7'(sram_cnt) + 7'(rd_inflight) + 7'(ob_cnt);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sram_cnt    <= '0;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
         last_grant  <= 1'b0;
         ob0         <= '0;
         ob1         <= '0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sram_cnt    <= '0;
         rd_inflight <= 1'b0;
         ob_cnt      <= 2'd0;
         last_grant  <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)
            rd_ptr <= rd_ptr + 1'b1;
         sram_cnt    <= sram_cnt + CW'(do_wr) - CW'(do_rd);
         rd_inflight <= do_rd;
         if (rd_elig && wr_req)
            last_grant <= do_rd;
         case ({pop_fire, fill})
            2'b11: begin
               if (ob_cnt == 2'd1) begin
                  ob0 <= fill_data;
               end else begin
                  ob0 <= ob1;
                  ob1 <= fill_data;
               end
            end
            2'b10: begin
               ob0    <= ob1;
               ob_cnt <= ob_cnt - 2'd1;
            end
            2'b01: begin
               if (ob_cnt == 2'd0)
                  ob0 <= fill_data;
               else
                  ob1 <= fill_data;
               ob_cnt <= ob_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aq_spsram_fifo_ctrl.sv
// Bench for aq_spsram_fifo_ctrl: SRAM model plus queue-based reference.
// Expected latency follows AQ_SPSRAM_FIFO_BYPASS_EN.
module tb_aq_spsram_fifo_ctrl;

   localparam int AW = 6;
   localparam int DW = 88;
`ifdef AQ_SPSRAM_FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          push_vld;
   logic          push_rdy;
   logic [DW-1:0] push_data;
   logic          pop_vld;
   logic          pop_rdy;
   logic [DW-1:0] pop_data;
   logic [6:0]    fifo_cnt;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   logic [DW-1:0] mem [0:63];

   aq_spsram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .forever_cpuclk(clk),
      .cpurst_b(rst_n),
      .flush(flush),
      .push_vld(push_vld),
      .push_rdy(push_rdy),
      .push_data(push_data),
      .pop_vld(pop_vld),
      .pop_rdy(pop_rdy),
      .pop_data(pop_data),
      .fifo_cnt(fifo_cnt),
      .sram_a(sram_a),
      .sram_cen(sram_cen),
      .sram_gwen(sram_gwen),
      .sram_wen(sram_wen),
      .sram_d(sram_d),
      .sram_q(sram_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!sram_cen) begin
         if (sram_gwen)
            mem[sram_a] <= (mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
         else
            sram_q <= mem[sram_a];
      end
   end

   logic [DW-1:0] exp_q[$];
   int            tests = 0;
   int            fails = 0;
   int            n_push = 0;
   int            n_pop = 0;
   bit            pv_s, pr_s, pf, of;
   bit            track = 0;
   bit            prev_rd = 0;
   int            rr = 0;
   logic [DW-1:0] last_pop;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      bit rd_now;
      @(negedge clk);
      pv_s = pop_vld;
      pr_s = push_rdy;
      pf   = push_vld && push_rdy;
      of   = pop_vld && pop_rdy;
      chk("fifo_cnt", DW'(fifo_cnt), DW'(exp_q.size()));
      if (of) begin
         chk("pop_nonempty", DW'(exp_q.size() != 0), DW'(1));
         if (exp_q.size() != 0)
            chk("pop_data", pop_data, exp_q[0]);
         last_pop = pop_data;
      end
      rd_now = !sram_cen && !sram_gwen;
      if (track && rd_now && prev_rd)
         rr++;
      prev_rd = rd_now && push_vld;
      @(posedge clk);
      if (of && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         n_pop++;
      end
      if (pf) begin
         exp_q.push_back(push_data);
         n_push++;
      end
      if (flush)
         exp_q.delete();
      #1;
   endtask

   task automatic push_n(input int n, input logic [DW-1:0] base);
      int acc = 0;
      for (int c = 0; c < 400 && acc < n; c++) begin
         push_vld  = 1'b1;
         push_data = base + DW'(acc);
         cyc();
         if (pf)
            acc++;
      end
      push_vld = 1'b0;
      chk("push_n_accepts", DW'(acc), DW'(n));
   endtask

   task automatic drain();
      push_vld = 1'b0;
      pop_rdy  = 1'b1;
      for (int c = 0; c < 600 && exp_q.size() != 0; c++)
         cyc();
      chk("drained", DW'(exp_q.size()), DW'(0));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pop_vld"}, DW'(pop_vld), DW'(0));
      chk({tag, "_fifo_cnt"}, DW'(fifo_cnt), DW'(0));
      chk({tag, "_cen"}, DW'(sram_cen), DW'(1));
      chk({tag, "_gwen"}, DW'(sram_gwen), DW'(0));
      chk({tag, "_wen"}, sram_wen, DW'(0));
      chk({tag, "_a"}, DW'(sram_a), DW'(0));
      chk({tag, "_push_rdy"}, DW'(push_rdy), DW'(1));
      chk({tag, "_pop_data"}, pop_data, DW'(0));
   endtask

   initial begin
      int k;
      int p0;
      int n0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      push_vld  = 1'b0;
      pop_rdy   = 1'b0;
      push_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("rst");
      rst_n = 1'b1;

      // single push latency
      pop_rdy   = 1'b1;
      push_vld  = 1'b1;
      push_data = 88'h0A5A5A5A5A5A5A5A5A5A5A;
      cyc();
      chk("single_accept", DW'(pf), DW'(1));
      push_vld  = 1'b0;
      push_data = '0;
      k = 0;
      do begin
         cyc();
         k++;
      end while (!pv_s && k < 10);
      chk("single_latency", DW'(k), DW'(LAT));
      chk("single_data", last_pop, 88'h0A5A5A5A5A5A5A5A5A5A5A);
      cyc();
      chk("single_cnt_after", DW'(fifo_cnt), DW'(0));

      // fill to 66, then drain in order across pointer wrap
      pop_rdy = 1'b0;
      push_n(66, '0);
      push_vld = 1'b1;
      repeat (3) cyc();
      chk("full_push_rdy", DW'(pr_s), DW'(0));
      chk("full_cnt", DW'(fifo_cnt), DW'(66));
      n0 = n_pop;
      drain();
      chk("full_drain_pops", DW'(n_pop - n0), DW'(66));
      chk("full_last", last_pop, DW'(65));

      // sustained push and pop
      p0 = n_push;
      n0 = n_pop;
      rr = 0;
      track = 1'b1;
      prev_rd = 1'b0;
      push_vld = 1'b1;
      pop_rdy  = 1'b1;
      repeat (200) begin
         push_data = DW'({$urandom, $urandom, $urandom});
         cyc();
      end
      track = 1'b0;
      chk("stream_back_to_back_reads", DW'(rr), DW'(0));
      chk("stream_throughput", DW'((n_push - p0) >= 80), DW'(1));
      drain();
      chk("stream_no_loss", DW'(n_push - p0), DW'(n_pop - n0));

      // random traffic
      repeat (500) begin
         push_vld  = ($urandom_range(0, 3) != 0);
         pop_rdy   = ($urandom_range(0, 1) != 0);
         push_data = DW'({$urandom, $urandom, $urandom});
         cyc();
      end
      drain();

      // flush with a loaded queue
      pop_rdy = 1'b0;
      push_n(5, DW'(88'h500));
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      chk("flush_pop_vld", DW'(pv_s), DW'(0));
      chk("flush_cnt", DW'(fifo_cnt), DW'(0));
      push_n(1, DW'(88'h123));
      drain();
      chk("flush_first_pop", last_pop, DW'(88'h123));

      // reset mid-stream with 10 entries held
      pop_rdy = 1'b0;
      push_n(10, DW'(88'h900));
      cyc();
      chk("pre_reset_cnt", DW'(fifo_cnt), DW'(10));
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      chk("post_reset_push_rdy", DW'(pr_s), DW'(1));
      chk("post_reset_pop_vld", DW'(pv_s), DW'(0));
      push_n(3, DW'(88'h777));
      drain();
      chk("post_reset_last", last_pop, DW'(88'h779));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
